// File: rtl/fifo_shift_store_if.sv
// Handshake and data bundle between the FIFO storage stage and its producer/status logic.
// The master side drives requests and gating flags; the slave side returns read data and occupancy.
interface fifo_shift_store_if #(
  parameter int width = 8
);
  logic             wr;
  logic             full;
  logic             rd_en;
  logic [width-1:0] data_in;
  logic [width-1:0] data_out;
  logic             dout_valid;
  logic [31:0]      wr_ptr;

  modport master (
    output wr, full, rd_en, data_in,
    input  data_out, dout_valid, wr_ptr
  );

  modport slave (
    input  wr, full, rd_en, data_in,
    output data_out, dout_valid, wr_ptr
  );
endinterface

// File: rtl/fifo_shift_store.sv
// Shift-register FIFO storage: the oldest word always sits in slot 0 and wr_ptr counts stored words.
// Reads register slot 0 into data_out with a one-cycle valid pulse; writes append behind the last word.
module fifo_shift_store #(
  parameter int width = 8,
  parameter int depth = 32
) (
  input  logic              clk,
  input  logic              rst,
  fifo_shift_store_if.slave bus
);

  localparam int AW = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] mem_q [depth];
  logic [width-1:0] mem_d [depth];
  logic [31:0]      wr_ptr_q, wr_ptr_d;
  logic [width-1:0] data_out_q, data_out_d;
  logic             dout_valid_q, dout_valid_d;
  logic             do_wr, do_rd;
  logic [AW-1:0]    wr_idx;

  // Requests are re-qualified locally so a misbehaving status stage cannot overrun or underrun storage
  assign do_wr = bus.wr & ~bus.full & (wr_ptr_q != 32'(depth));
  assign do_rd = bus.rd_en & (wr_ptr_q != 32'd0);

  // On a combined read/write the shift frees a slot, so the new word lands one position lower
  assign wr_idx = do_rd ? AW'(wr_ptr_q - 32'd1) : AW'(wr_ptr_q);

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    data_out_d   = data_out_q;
    dout_valid_d = 1'b0;

    if (do_rd) begin
      for (int i = 0; i < depth - 1; i++) begin
        mem_d[i] = mem_q[i + 1];
      end
      data_out_d   = mem_q[0];
      dout_valid_d = 1'b1;
    end

    if (do_wr) begin
      mem_d[wr_idx] = bus.data_in;
    end

    if (do_wr && !do_rd) begin
      wr_ptr_d = wr_ptr_q + 32'd1;
    end else if (do_rd && !do_wr) begin
      wr_ptr_d = wr_ptr_q - 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= 32'd0;
      data_out_q   <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      data_out_q   <= data_out_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Storage is never cleared; reset only suppresses any request arriving with it
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= mem_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.wr_ptr     = wr_ptr_q;

endmodule

// File: tb/tb_fifo_shift_store.sv
// Randomized and directed bench for fifo_shift_store (depth 4) against a queue-based FIFO model.
// Each cycle the registered outputs are compared with the model after the rising edge.
module tb_fifo_shift_store;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_shift_store_if #(.width(WIDTH)) bus ();

  fifo_shift_store #(.width(WIDTH), .depth(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] exp_dout = '0;
  logic             exp_vld  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of raw inputs, advance the model, and compare all outputs
  task automatic step(input logic r, input logic w, input logic f, input logic re,
                      input logic [WIDTH-1:0] d);
    logic dw, dr;
    @(negedge clk);
    rst         = r;
    bus.wr      = w;
    bus.full    = f;
    bus.rd_en   = re;
    bus.data_in = d;
    @(posedge clk);
    if (r) begin
      q.delete();
      exp_dout = '0;
      exp_vld  = 1'b0;
    end else begin
      dw = w && !f && (q.size() != DEPTH);
      dr = re && (q.size() != 0);
      if (dr) begin
        exp_dout = q.pop_front();
        exp_vld  = 1'b1;
      end else begin
        exp_vld  = 1'b0;
      end
      if (dw) q.push_back(d);
    end
    #1;
    chk("wr_ptr", bus.wr_ptr, 32'(q.size()));
    chk("data_out", 32'(bus.data_out), 32'(exp_dout));
    chk("dout_valid", 32'(bus.dout_valid), 32'(exp_vld));
  endtask

  // Behaves like the status stage: full from occupancy, rd_en gated by non-empty
  task automatic cyc(input logic w, input logic rd, input logic [WIDTH-1:0] d);
    step(1'b0, w, q.size() == DEPTH, rd && (q.size() != 0), d);
  endtask

  initial begin
    bus.wr = 1'b0; bus.full = 1'b0; bus.rd_en = 1'b0; bus.data_in = '0;

    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_ptr", bus.wr_ptr, 32'd0);
    chk("rst_vld", 32'(bus.dout_valid), 32'd0);

    cyc(1'b1, 1'b0, 8'h11); chk("fill_ptr1", bus.wr_ptr, 32'd1);
    cyc(1'b1, 1'b0, 8'h22); chk("fill_ptr2", bus.wr_ptr, 32'd2);
    cyc(1'b1, 1'b0, 8'h33); chk("fill_ptr3", bus.wr_ptr, 32'd3);
    chk("fill_dout", 32'(bus.data_out), 32'h00);

    cyc(1'b0, 1'b1, 8'h00); chk("rd1", 32'(bus.data_out), 32'h11); chk("rd1_ptr", bus.wr_ptr, 32'd2);
    cyc(1'b0, 1'b1, 8'h00); chk("rd2", 32'(bus.data_out), 32'h22); chk("rd2_ptr", bus.wr_ptr, 32'd1);
    cyc(1'b0, 1'b1, 8'h00); chk("rd3", 32'(bus.data_out), 32'h33); chk("rd3_ptr", bus.wr_ptr, 32'd0);

    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(8'hA0 + i));
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF);
    chk("ovf_ptr", bus.wr_ptr, 32'd4);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk("ovf_drain", 32'(bus.data_out), 32'(8'hA0 + i));
    end

    cyc(1'b1, 1'b0, 8'h05);
    cyc(1'b1, 1'b0, 8'h06);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h07);
    chk("rw_dout", 32'(bus.data_out), 32'h05);
    chk("rw_ptr", bus.wr_ptr, 32'd2);
    cyc(1'b0, 1'b1, 8'h00); chk("rw_rd1", 32'(bus.data_out), 32'h06);
    cyc(1'b0, 1'b1, 8'h00); chk("rw_rd2", 32'(bus.data_out), 32'h07);

    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(8'hB0 + i));
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'hCC);
    chk("full_rw_dout", 32'(bus.data_out), 32'hB0);
    chk("full_rw_ptr", bus.wr_ptr, 32'd3);
    for (int i = 1; i < 4; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk("full_rw_drain", 32'(bus.data_out), 32'(8'hB0 + i));
    end

    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i));
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h99);
    chk("mid_rst_ptr", bus.wr_ptr, 32'd0);
    chk("mid_rst_dout", 32'(bus.data_out), 32'h00);
    chk("mid_rst_vld", 32'(bus.dout_valid), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("empty_rd_vld", 32'(bus.dout_valid), 32'd0);
    chk("empty_rd_ptr", bus.wr_ptr, 32'd0);

    // Random traffic, mostly well-gated, with occasional forced flags and resets
    for (int n = 0; n < 600; n++) begin
      logic w, rd, f, re, r;
      logic [WIDTH-1:0] d;
      w  = ($urandom_range(0, 99) < 55);
      rd = ($urandom_range(0, 99) < 45);
      d  = WIDTH'($urandom);
      r  = ($urandom_range(0, 63) == 0);
      f  = (q.size() == DEPTH);
      re = rd && (q.size() != 0);
      if ($urandom_range(0, 9) == 0) f  = 1'($urandom);
      if ($urandom_range(0, 9) == 0) re = rd;
      step(r, w, f, re, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_shift_store.md
Name: fifo_shift_store

Overview:
- Storage and occupancy stage of the FIFO. It holds the data words and maintains the occupancy pointer `wr_ptr`, which the status-signal stage turns into full/empty/overflow/underflow/rd_en.
- It consumes the gated `rd_en` and `full` from that stage and produces the registered read data.
- The storage is a shift-register FIFO: the oldest word is always in slot 0, and `wr_ptr` equals the number of stored words.

Parameters:
- width, 8, data word width in bits
- depth, 32, number of storage slots; `wr_ptr` range is 0..depth

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- wr  input  1  write request from the producer
- full  input  1  full flag from the status stage (wr_ptr == depth)
- rd_en  input  1  gated read enable from the status stage (~empty & rd)
- data_in  input  width  write data, sampled on a cycle with an accepted write
- data_out  output  width  registered read data
- dout_valid  output  1  one-cycle pulse: `data_out` updated this cycle
- wr_ptr  output  32  occupancy count, 0..depth, registered

Behaviour:
- Reset:
  - `rst` high at a rising edge clears `wr_ptr`, `data_out` and `dout_valid` to 0.
  - Storage slots are not cleared.
  - Reset dominates any `wr`/`rd_en` in the same cycle; those requests are discarded.
  - Reset mid-operation empties the FIFO in one cycle. The next cycle sees `wr_ptr`=0.
- Internal qualification (defensive, independent of upstream gating):
  - do_wr = wr & ~full & (wr_ptr != depth)
  - do_rd = rd_en & (wr_ptr != 0)
- Read (do_rd):
  - `data_out` <= slot[0]; `dout_valid` <= 1 in the next cycle. Latency is 1 clock from the `rd_en` edge.
  - All slots shift down: slot[i] <= slot[i+1] for i = 0..depth-2.
  - slot[depth-1] keeps its value; it is don't-care.
- No read:
  - `data_out` holds its value; `dout_valid` <= 0.
- Write only (do_wr & ~do_rd):
  - slot[wr_ptr] <= `data_in`.
  - `wr_ptr` <= wr_ptr+1.
- Read only (do_rd & ~do_wr):
  - `wr_ptr` <= wr_ptr-1.
- Simultaneous read and write (do_rd & do_wr):
  - Shift first, then write `data_in` to slot[wr_ptr-1].
  - `wr_ptr` unchanged.
  - Ordering is preserved: the new word lands behind all remaining words.
- Write when full:
  - The write is dropped; storage and `wr_ptr` are unchanged. The status stage flags overflow.
  - If `rd_en` is also high, the read proceeds, `wr_ptr` <= depth-1, and the write is still dropped (`full` was high).
- Read when empty:
  - `rd_en` is low from upstream. If it is forced high, do_rd=0: no shift, `dout_valid`=0, `wr_ptr` stays 0.
- Width rules:
  - `wr_ptr` is 32-bit unsigned and never exceeds depth or goes below 0. There is no wrap-around.
  - Slot index uses the low clog2(depth) bits of wr_ptr or wr_ptr-1. An index equal to depth is never used, because writes are blocked at full.
- No combinational path from any input to any output.

Test Plan:
- Reset, then write 0x11, 0x22, 0x33 on consecutive cycles (depth=4) -> `wr_ptr` goes 1,2,3; `dout_valid` stays 0; `data_out`=0x00.
- From that state, read 3 times consecutively -> `data_out` is 0x11, 0x22, 0x33 on the cycles after each `rd_en`; `dout_valid` is high for 3 cycles; `wr_ptr` goes 2,1,0.
- Fill to 4 (0xA0..0xA3), then `wr`=1 with `full`=1 and data 0xFF -> `wr_ptr` stays 4; subsequent reads return 0xA0..0xA3, and 0xFF never appears.
- Simultaneous case: with 2 words held (0x05, 0x06), assert `wr`=1 (data 0x07) and `rd_en`=1 together -> `data_out`=0x05 next cycle, `wr_ptr` stays 2; following reads return 0x06 then 0x07.
- Full plus simultaneous read/write: at `wr_ptr`=4 (0xB0..0xB3), `wr`=1 (0xCC), `full`=1, `rd_en`=1 -> `data_out`=0xB0, `wr_ptr`=3; draining yields 0xB1, 0xB2, 0xB3, with no 0xCC.
- Reset mid-operation: with `wr_ptr`=3, assert `rst` together with `wr`=1 and `rd_en`=1 -> next cycle `wr_ptr`=0, `data_out`=0, `dout_valid`=0. A later forced `rd_en`=1 while empty -> no `dout_valid` and `wr_ptr` stays 0.
